// File: rtl/sdram_chan_arbiter_if.sv
// Bundle between the two SampleStorage requesters, the channel arbiter and the SDRAM
// controller handshake (we/re/busy/read_ready).
interface sdram_chan_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 24
);
    logic [1:0]             req_wr;
    logic [1:0]             req_rd;
    logic [1:0][ADDR_W-1:0] req_waddr;
    logic [1:0][ADDR_W-1:0] req_raddr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             grant;
    logic [1:0]             ack;
    logic [DATA_W-1:0]      rdata;
    logic                   err;
    logic                   we;
    logic                   re;
    logic [ADDR_W-1:0]      waddress;
    logic [ADDR_W-1:0]      raddress;
    logic [DATA_W-1:0]      writedata;
    logic [DATA_W-1:0]      readdata;
    logic                   read_ready;
    logic                   busy;

    // Environment side: requesters plus the SDRAM controller.
    modport master (
        output req_wr, req_rd, req_waddr, req_raddr, req_wdata, readdata, read_ready, busy,
        input  grant, ack, rdata, err, we, re, waddress, raddress, writedata
    );

    // Arbiter side.
    modport slave (
        input  req_wr, req_rd, req_waddr, req_raddr, req_wdata, readdata, read_ready, busy,
        output grant, ack, rdata, err, we, re, waddress, raddress, writedata
    );
endinterface

// File: rtl/sdram_chan_arbiter.sv
// Round-robin slot arbiter sharing one SDRAM controller between two sample channels.
// Define SDRAM_ARB_TIMEOUT_EN to abort accesses stalled for TIMEOUT_CYC cycles (err=1).
module sdram_chan_arbiter #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic                 CLOCK_50_D,
    input logic                 AUD_ADCLRCK,
    sdram_chan_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StIssueW,
        StWAcc,
        StWDone,
        StIssueR,
        StRWait,
        StFin
    } state_e;

    state_e            state_q;
    logic              rr_q;
    logic              owner_q;
    logic [1:0]        grant_q;
    logic [1:0]        ack_q;
    logic              err_q;
    logic              we_q;
    logic              re_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [1:0] req_any;
    logic       pick;
    logic       tmo;

    always_comb begin
        req_any = bus.req_wr | bus.req_rd;
        pick    = (&req_any) ? rr_q : req_any[1];
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_cur;
    state_e          last_q;
    logic            timed;

    // The count restarts on the first cycle of every state.
    always_comb begin
        cnt_cur = (state_q != last_q) ? '0 : cnt_q;
        timed   = state_q inside {StIssueW, StWAcc, StWDone, StIssueR, StRWait};
        tmo     = timed && (cnt_cur == CntW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge CLOCK_50_D or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            cnt_q  <= '0;
            last_q <= StIdle;
        end else begin
            cnt_q  <= cnt_cur + 1'b1;
            last_q <= state_q;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLOCK_50_D or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            if (tmo) begin
                state_q <= StFin;
                ack_q   <= grant_q;
                err_q   <= 1'b1;
                rdata_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (|req_any) begin
                            owner_q <= pick;
                            grant_q <= pick ? 2'b10 : 2'b01;
                            state_q <= bus.req_wr[pick] ? StIssueW : StIssueR;
                        end
                    end
                    StIssueW: begin
                        if (!bus.busy) begin
                            we_q    <= 1'b1;
                            waddr_q <= bus.req_waddr[owner_q];
                            wdata_q <= bus.req_wdata[owner_q];
                            state_q <= StWAcc;
                        end
                    end
                    StWAcc: begin
                        if (bus.busy) state_q <= StWDone;
                    end
                    StWDone: begin
                        if (!bus.busy) begin
                            if (bus.req_rd[owner_q]) begin
                                state_q <= StIssueR;
                            end else begin
                                state_q <= StFin;
                                ack_q   <= grant_q;
                            end
                        end
                    end
                    StIssueR: begin
                        if (!bus.busy) begin
                            re_q    <= 1'b1;
                            raddr_q <= bus.req_raddr[owner_q];
                            state_q <= StRWait;
                        end
                    end
                    StRWait: begin
                        // Only a read_ready seen here belongs to this slot.
                        if (bus.read_ready) begin
                            rdata_q <= bus.readdata;
                            state_q <= StFin;
                            ack_q   <= grant_q;
                        end
                    end
                    StFin: begin
                        ack_q   <= '0;
                        err_q   <= 1'b0;
                        grant_q <= '0;
                        rr_q    <= ~owner_q;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.we        = we_q;
    assign bus.re        = re_q;
    assign bus.waddress  = waddr_q;
    assign bus.raddress  = raddr_q;
    assign bus.writedata = wdata_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_sdram_chan_arbiter.sv
// Self-checking bench for sdram_chan_arbiter: vector table, corner-case sequences and a
// randomized phase scored against a slot-level reference model.
`timescale 1ns/1ps
module tb_sdram_chan_arbiter;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 24;
    localparam int unsigned TMO = 64;

    logic clk  = 1'b0;
    logic lrck = 1'b1;
    always #10 clk = ~clk;

    sdram_chan_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sdram_chan_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLOCK_50_D (clk),
        .AUD_ADCLRCK(lrck),
        .bus        (bus)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: busy for lat cycles after an accepted we/re, read_ready as busy drops.
    int              lat        = 3;
    bit              busy_force = 1'b0;
    bit              rr_drop    = 1'b0;
    bit              ovr_en     = 1'b0;
    logic [DW-1:0]   ovr_val    = '0;
    int              ctl_cnt    = 0;
    bit              ctl_rd     = 1'b0;
    logic [AW-1:0]   ctl_raddr  = '0;
    logic            ctl_busy   = 1'b0;
    logic            ctl_rdy    = 1'b0;
    logic [DW-1:0]   ctl_data   = '0;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A3C ^ {a[23:16], 8'h00};
    endfunction

    always @(posedge clk) begin
        ctl_rdy <= 1'b0;
        if (ctl_cnt > 0) begin
            ctl_cnt <= ctl_cnt - 1;
            if (ctl_cnt == 1) begin
                ctl_busy <= 1'b0;
                if (ctl_rd && !rr_drop) begin
                    ctl_rdy  <= 1'b1;
                    ctl_data <= ovr_en ? ovr_val : data_of(ctl_raddr);
                end
            end
        end else if (bus.we || bus.re) begin
            ctl_busy  <= 1'b1;
            ctl_cnt   <= lat;
            ctl_rd    <= bus.re;
            ctl_raddr <= bus.raddress;
        end
    end

    assign bus.busy       = ctl_busy | busy_force;
    assign bus.read_ready = ctl_rdy;
    assign bus.readdata   = ctl_data;

    // Handshake invariants hold on every cycle.
    always @(negedge clk) begin
        check("we_re_overlap", bus.we & bus.re, 0);
        check("issue_while_busy", (bus.we | bus.re) & bus.busy, 0);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", nerr);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int            ch;
        bit            wr;
        bit            rd;
        logic [AW-1:0] waddr;
        logic [AW-1:0] raddr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rval;
        logic [1:0]    exp_grant;
        logic [DW-1:0] exp_rdata;
        int            exp_we;
        int            exp_re;
    } vec_t;

    vec_t vecs[4];

    task automatic idle_reqs();
        bus.req_wr = '0;
        bus.req_rd = '0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int            t_iss = -1;
        int            n_we = 0;
        int            n_re = 0;
        int            bad_grant = 0;
        bit            got = 1'b0;
        logic [AW-1:0] wa = '0;
        logic [AW-1:0] ra = '0;
        logic [DW-1:0] wd = '0;
        ovr_en  = 1'b1;
        ovr_val = v.rval;
        bus.req_wr[v.ch]    = v.wr;
        bus.req_rd[v.ch]    = v.rd;
        bus.req_waddr[v.ch] = v.waddr;
        bus.req_raddr[v.ch] = v.raddr;
        bus.req_wdata[v.ch] = v.wdata;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if ((bus.we || bus.re) && t_iss < 0) t_iss = t;
            if (bus.we) begin n_we++; wa = bus.waddress; wd = bus.writedata; end
            if (bus.re) begin n_re++; ra = bus.raddress; end
            if (bus.grant !== v.exp_grant) bad_grant++;
            if (bus.ack != 0) begin
                got = 1'b1;
                check($sformatf("v%0d_ack", i), bus.ack, v.exp_grant);
                check($sformatf("v%0d_rdata", i), bus.rdata, v.exp_rdata);
                check($sformatf("v%0d_err", i), bus.err, 0);
                idle_reqs();
            end
        end
        if (!got) check($sformatf("v%0d_ack_seen", i), 0, 1);
        check($sformatf("v%0d_grant_held", i), bad_grant, 0);
        check($sformatf("v%0d_first_issue", i), t_iss, 1);
        check($sformatf("v%0d_we_count", i), n_we, v.exp_we);
        check($sformatf("v%0d_re_count", i), n_re, v.exp_re);
        if (v.wr) begin
            check($sformatf("v%0d_waddress", i), wa, v.waddr);
            check($sformatf("v%0d_writedata", i), wd, v.wdata);
        end
        if (v.rd) check($sformatf("v%0d_raddress", i), ra, v.raddr);
        @(negedge clk);
        check($sformatf("v%0d_ack_pulse", i), bus.ack, 0);
        check($sformatf("v%0d_grant_clear", i), bus.grant, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        lrck = 1'b1;
        repeat (3) @(negedge clk);
        lrck = 1'b0;
    endtask

    // Randomized-phase requester state and slot scoreboard.
    bit            pend[2];
    bit            p_wr[2];
    bit            p_rd[2];
    logic [AW-1:0] p_wa[2];
    logic [AW-1:0] p_ra[2];
    logic [DW-1:0] p_wd[2];

    initial begin
        int            k;
        int            kack;
        bit            seen;
        bit            got;
        int            n_iss;
        int            early;
        int            owner;
        int            exp_owner;
        int            rr_exp;
        int            acks;
        int            s_we;
        int            s_re;
        logic [AW-1:0] s_wa;
        logic [AW-1:0] s_ra;
        logic [DW-1:0] s_wd;
        logic [1:0]    prev_req;
        logic [1:0]    r;

        vecs[0] = '{ch: 0, wr: 1, rd: 0, waddr: 24'h000010, raddr: 24'h0, wdata: 16'h1234,
                    rval: 16'h0, exp_grant: 2'b01, exp_rdata: 16'h0000, exp_we: 1, exp_re: 0};
        vecs[1] = '{ch: 1, wr: 1, rd: 1, waddr: 24'h000020, raddr: 24'h000008, wdata: 16'h5555,
                    rval: 16'hBEEF, exp_grant: 2'b10, exp_rdata: 16'hBEEF, exp_we: 1, exp_re: 1};
        vecs[2] = '{ch: 0, wr: 0, rd: 1, waddr: 24'h0, raddr: 24'h123456, wdata: 16'h0,
                    rval: 16'h0F0F, exp_grant: 2'b01, exp_rdata: 16'h0F0F, exp_we: 0, exp_re: 1};
        vecs[3] = '{ch: 1, wr: 1, rd: 0, waddr: 24'hABCDEF, raddr: 24'h0, wdata: 16'hCAFE,
                    rval: 16'h0, exp_grant: 2'b10, exp_rdata: 16'h0F0F, exp_we: 1, exp_re: 0};

        idle_reqs();
        bus.req_waddr = '0;
        bus.req_raddr = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_grant", bus.grant, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_we_re", {bus.we, bus.re}, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_err", bus.err, 0);
        check("rst_waddress", bus.waddress, 0);
        lrck = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Both channels request continuously from reset: strict alternation.
        ovr_en = 1'b0;
        @(negedge clk);
        lrck = 1'b1;
        bus.req_wr = 2'b11;
        bus.req_waddr[0] = 24'h000100;
        bus.req_waddr[1] = 24'h000200;
        repeat (2) @(negedge clk);
        lrck = 1'b0;
        k = 0;
        for (int t = 0; t < 300 && k < 4; t++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                check($sformatf("alt_ack%0d", k), bus.ack, (k % 2 == 1) ? 2 : 1);
                check($sformatf("alt_grant%0d", k), bus.grant, (k % 2 == 1) ? 2 : 1);
                k++;
            end
        end
        idle_reqs();
        if (k < 4) check("alt_ack_count", k, 4);
        repeat (2) @(negedge clk);

        // Controller busy before the request: no issue until it drops, then within a cycle.
        busy_force = 1'b1;
        bus.req_wr[0]    = 1'b1;
        bus.req_waddr[0] = 24'h000077;
        bus.req_wdata[0] = 16'h7777;
        n_iss = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.we || bus.re) n_iss++;
        end
        check("busy_no_issue", n_iss, 0);
        busy_force = 1'b0;
        @(negedge clk);
        check("busy_issue_next", bus.we, 1);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                got = 1'b1;
                check("busy_ack", bus.ack, 2'b01);
                idle_reqs();
            end
        end
        if (!got) check("busy_ack_seen", 0, 1);
        repeat (2) @(negedge clk);

        // LRCK rises mid-read; the stale read_ready must not complete anything.
        lat = 10;
        bus.req_rd[0]    = 1'b1;
        bus.req_raddr[0] = 24'h000044;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bus.re) seen = 1'b1;
        end
        check("rst_mid_re_seen", seen, 1);
        repeat (2) @(negedge clk);
        #3 lrck = 1'b1;
        #1;
        check("async_grant", bus.grant, 0);
        check("async_raddress", bus.raddress, 0);
        check("async_rdata", bus.rdata, 0);
        check("async_we_re", {bus.we, bus.re}, 0);
        idle_reqs();
        repeat (2) @(negedge clk);
        lrck = 1'b0;
        bus.req_rd[0]    = 1'b1;
        bus.req_raddr[0] = 24'h000088;
        got   = 1'b0;
        early = 0;
        for (int t = 0; t < 80 && !got; t++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                got = 1'b1;
                check("post_rst_ack", bus.ack, 2'b01);
                check("post_rst_rdata", bus.rdata, data_of(24'h000088));
            end else if (bus.rdata != 0) begin
                early++;
            end
        end
        if (!got) check("post_rst_ack_seen", 0, 1);
        check("stale_rdy_ignored", early, 0);
        idle_reqs();
        lat = 3;
        repeat (2) @(negedge clk);

        // Controller never returns read data.
        rr_drop = 1'b1;
        bus.req_rd[0]    = 1'b1;
        bus.req_raddr[0] = 24'h000099;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bus.re) seen = 1'b1;
        end
        kack = 0;
        for (int t = 1; t <= 100 && kack == 0; t++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                kack = t;
`ifdef SDRAM_ARB_TIMEOUT_EN
                check("tmo_err", bus.err, 1);
                check("tmo_rdata", bus.rdata, 0);
                check("tmo_ack", bus.ack, 2'b01);
`endif
            end
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        check("tmo_cycles", kack, TMO);
`else
        check("no_tmo_ack", kack, 0);
        check("no_tmo_grant", bus.grant, 2'b01);
        check("no_tmo_err", bus.err, 0);
`endif
        idle_reqs();
        rr_drop = 1'b0;
        repeat (15) @(negedge clk);
        do_reset();

        // Randomized traffic against the slot-level model.
        ovr_en   = 1'b0;
        prev_req = '0;
        rr_exp   = 0;
        owner    = -1;
        acks     = 0;
        s_we = 0; s_re = 0; s_wa = '0; s_ra = '0; s_wd = '0;
        for (int c = 0; c < 2; c++) pend[c] = 1'b0;
        for (int cy = 0; cy < 1500; cy++) begin
            @(negedge clk);
            if (owner < 0 && bus.grant != 0) begin
                owner     = bus.grant[1] ? 1 : 0;
                exp_owner = (prev_req == 2'b11) ? rr_exp : (prev_req[1] ? 1 : 0);
                check("rand_grant", bus.grant, (exp_owner == 1) ? 2'b10 : 2'b01);
                s_we = 0;
                s_re = 0;
            end
            if (bus.we) begin s_we++; s_wa = bus.waddress; s_wd = bus.writedata; end
            if (bus.re) begin s_re++; s_ra = bus.raddress; end
            if (bus.ack != 0) begin
                if (owner < 0) begin
                    check("rand_orphan_ack", bus.ack, 0);
                end else begin
                    acks++;
                    check("rand_ack", bus.ack, (owner == 1) ? 2'b10 : 2'b01);
                    check("rand_err", bus.err, 0);
                    check("rand_we_count", s_we, p_wr[owner]);
                    check("rand_re_count", s_re, p_rd[owner]);
                    if (p_wr[owner]) begin
                        check("rand_waddress", s_wa, p_wa[owner]);
                        check("rand_writedata", s_wd, p_wd[owner]);
                    end
                    if (p_rd[owner]) begin
                        check("rand_raddress", s_ra, p_ra[owner]);
                        check("rand_rdata", bus.rdata, data_of(p_ra[owner]));
                    end
                    rr_exp = 1 - owner;
                    pend[owner] = 1'b0;
                    bus.req_wr[owner] = 1'b0;
                    bus.req_rd[owner] = 1'b0;
                    owner = -1;
                end
            end
            lat = $urandom_range(1, 5);
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && $urandom_range(0, 3) == 0) begin
                    r       = 2'($urandom_range(1, 3));
                    pend[c] = 1'b1;
                    p_wr[c] = r[0];
                    p_rd[c] = r[1];
                    p_wa[c] = AW'($urandom);
                    p_ra[c] = AW'($urandom);
                    p_wd[c] = DW'($urandom);
                    bus.req_wr[c]    = p_wr[c];
                    bus.req_rd[c]    = p_rd[c];
                    bus.req_waddr[c] = p_wa[c];
                    bus.req_raddr[c] = p_ra[c];
                    bus.req_wdata[c] = p_wd[c];
                end
            end
            prev_req = bus.req_wr | bus.req_rd;
        end
        check("rand_progress", acks > 50, 1);
        idle_reqs();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/sdram_chan_arbiter.md
Name: sdram_chan_arbiter

Overview:
- Shares the single-port hardware SDRAM controller between the left and right SampleStorage requesters.
- Replaces the free-running AUD_ADCLRCK-phase mux.
- Runs one transaction slot per granted channel (optional write, then optional read) using round-robin arbitration, and sequences the controller's we/re/busy/rd_ready handshake.
- Services the delay-line traffic of both channels within each LRCK-low half-frame.

Parameters:
- DATA_W, 16, sample/data width.
- ADDR_W, 24, SDRAM word address width.
- TIMEOUT_CYC, 64, max cycles waited on the controller per access (used only with the optional feature).

Ports:
- CLOCK_50_D  in  1  system clock
- AUD_ADCLRCK  in  1  reset, asynchronous, active-high
- req_wr  in  2  per-channel write request, level, held until ack
- req_rd  in  2  per-channel read request, level, held until ack
- req_waddr  in  2xADDR_W  per-channel write address
- req_raddr  in  2xADDR_W  per-channel read address
- req_wdata  in  2xDATA_W  per-channel write data
- grant  out  2  one-hot current slot owner
- ack  out  2  one-cycle pulse, slot complete for that channel
- rdata  out  DATA_W  read data captured for the slot; valid with ack if that slot read
- err  out  1  one-cycle pulse with ack when the slot aborted
- we  out  1  controller write enable
- re  out  1  controller read enable
- waddress  out  ADDR_W  controller write address
- raddress  out  ADDR_W  controller read address
- writedata  out  DATA_W  controller write data
- readdata  in  DATA_W  controller read data
- read_ready  in  1  controller read-data-valid pulse
- busy  in  1  controller busy

Behaviour:
- Reset is AUD_ADCLRCK: asynchronous, active-high. Clock is CLOCK_50_D. The block is held in reset for the whole LRCK-high half-frame and works only while LRCK is low.
- Reset values: state IDLE, rr_ptr=0, all outputs 0 (grant, ack, err, we, re, addresses, writedata, rdata).
- States:
  - IDLE: if either channel has req_wr|req_rd, pick the owner. If both request, the owner is rr_ptr; otherwise the sole requester. Register grant; go to ISSUE_W if the owner's req_wr, else ISSUE_R.
  - ISSUE_W: wait while busy=1. When busy=0, drive we=1 for exactly one cycle with waddress/writedata from the owner; go to W_ACC.
  - W_ACC: wait for busy=1, then W_DONE.
  - W_DONE: wait for busy=0. If the owner's req_rd, go to ISSUE_R; else go to FIN.
  - ISSUE_R: when busy=0, drive re=1 for one cycle with raddress; go to R_WAIT.
  - R_WAIT: on read_ready=1, capture readdata into rdata; go to FIN.
  - FIN: pulse ack[owner] for one cycle, clear grant, set rr_ptr = ~owner, return to IDLE.
- Latency: request sampled in IDLE at cycle N → grant at N+1 → earliest we/re at N+2.
- Addresses/data are registered from the owner's inputs in the ISSUE cycle only. They hold until the next ISSUE; requester changes mid-slot are ignored.
- we and re are never high together, and are never asserted while busy=1.
- read_ready outside R_WAIT is ignored, e.g. stale data from a transaction aborted by reset.
- Requests are not latched. A request dropped before grant is simply never serviced. A request dropped mid-slot still completes the slot, and ack still pulses.
- Reset mid-slot (LRCK rises): abort immediately, no ack. The controller may finish the access. In the next frame, ISSUE waits for busy=0 before issuing.
- A request arriving in FIN is considered in the following IDLE cycle.

Optional Feature:
- SDRAM_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in ISSUE_W, W_ACC, W_DONE, ISSUE_R and R_WAIT, and restarts on each state entry.
  - Reaching TIMEOUT_CYC jumps to FIN with err=1 alongside ack; rdata=0 if the read was not completed.
- Undefined: no counter. The FSM waits indefinitely; err is tied 0.

Test Plan:
- LRCK low, ch0 req_wr waddr=0x000010 wdata=0x1234; controller model busy 3 cycles → single we pulse with those values, ack[0] after busy falls, grant=01 throughout, err=0.
- ch1 req_wr+req_rd (waddr 0x20, raddr 0x08); model returns 0xBEEF on read_ready → we then re, never overlapping; rdata=0xBEEF coincident with ack[1].
- Both channels request continuously from reset → grants alternate 01,10,01,10; ack order 0,1,0,1.
- Assert AUD_ADCLRCK during R_WAIT, then deliver read_ready → outputs zero asynchronously, no ack. After LRCK falls, a stale read_ready is ignored and the next ISSUE waits for busy=0.
- busy held 1 when ch0 requests → no we/re until busy=0, then issue within 1 cycle.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=64, read_ready never arrives → ack[0] and err pulse 64 cycles after R_WAIT entry, rdata=0. Without the macro, the FSM stays in R_WAIT.
